// File: rtl/pts_tx_controller.sv
// Async serial transmit sequencer for a flex parallel-to-serial shift register.
// Frames each accepted word as start bit, NUM_BITS data bits and STOP_BITS stop bits.
module pts_tx_controller #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                tx_ready,
  output logic [NUM_BITS-1:0] sr_data,
  output logic                load_enable,
  output logic                shift_enable,
  input  logic                sr_serial,
  output logic                tx_line,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int TW = $clog2(CLKS_PER_BIT * STOP_BITS + 1);
  localparam int CW = $clog2(NUM_BITS + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_bit_timer;
  logic [CW-1:0] r_bit_count;
  logic          w_bit_end;
  logic          w_stop_end;

  assign w_bit_end  = (r_bit_timer == BIT_LAST);
  assign w_stop_end = (r_bit_timer == STOP_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    tx_ready     = 1'b0;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    tx_line      = 1'b1;
    tx_busy      = 1'b1;
    tx_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
        if (tx_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        load_enable = 1'b1;
        w_next      = S_START;
      end
      S_START: begin
        tx_line = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        // Shift at the end of every bit period, including the last data bit.
        tx_line      = sr_serial;
        shift_enable = w_bit_end;
        if (w_bit_end && (r_bit_count == CNT_LAST)) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_stop_end) w_next = S_DONE;
      end
      S_DONE: begin
        tx_done = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_timer <= '0;
      r_bit_count <= '0;
    end else begin
      case (r_state)
        S_START: r_bit_timer <= w_bit_end ? '0 : r_bit_timer + 1'b1;
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_timer <= '0;
            r_bit_count <= (r_bit_count == CNT_LAST) ? '0 : r_bit_count + 1'b1;
          end else begin
            r_bit_timer <= r_bit_timer + 1'b1;
          end
        end
        S_STOP: r_bit_timer <= w_stop_end ? '0 : r_bit_timer + 1'b1;
        default: begin
          r_bit_timer <= '0;
          r_bit_count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                          sr_data <= '0;
    else if (r_state == S_IDLE && tx_valid) sr_data <= tx_data;
  end

endmodule

// File: tb/tb_pts_tx_controller.sv
// Directed bench for pts_tx_controller with an MSB-first shift register model.
// Two instances: C=10/1 stop bit and C=1/2 stop bits.
module tb_pts_tx_controller;

  logic       clk;
  logic       n_rst;

  logic       tx_valid, tx_ready, load_enable, shift_enable, sr_serial;
  logic       tx_line, tx_busy, tx_done;
  logic [7:0] tx_data, sr_data, r_sr;

  logic       f_valid, f_ready, f_load, f_shift, f_serial;
  logic       f_line, f_busy, f_done;
  logic [7:0] f_data, f_sr_data, r_fsr;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pts_tx_controller #(.NUM_BITS(8), .CLKS_PER_BIT(10), .STOP_BITS(1)) dut (
    .clk(clk), .n_rst(n_rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .sr_data(sr_data), .load_enable(load_enable), .shift_enable(shift_enable),
    .sr_serial(sr_serial), .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  pts_tx_controller #(.NUM_BITS(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_fast (
    .clk(clk), .n_rst(n_rst), .tx_valid(f_valid), .tx_data(f_data), .tx_ready(f_ready),
    .sr_data(f_sr_data), .load_enable(f_load), .shift_enable(f_shift),
    .sr_serial(f_serial), .tx_line(f_line), .tx_busy(f_busy), .tx_done(f_done)
  );

  // MSB-first parallel-to-serial shift registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            r_sr <= '0;
    else if (load_enable)  r_sr <= sr_data;
    else if (shift_enable) r_sr <= {r_sr[6:0], 1'b0};
  end
  assign sr_serial = r_sr[7];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       r_fsr <= '0;
    else if (f_load)  r_fsr <= f_sr_data;
    else if (f_shift) r_fsr <= {r_fsr[6:0], 1'b0};
  end
  assign f_serial = r_fsr[7];

  // Waits for tx_ready, presents d, and returns at the LOAD-cycle sample point.
  task automatic start_frame(input logic [7:0] d, input string nm);
    int waited;
    waited = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_timeout got=%b want=1", nm, tx_ready);
    end
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
  endtask

  // Called at the LOAD-cycle sample point (cycle 1 of the frame).
  task automatic watch_frame(input logic [7:0] d, input int inject_at, input bit hold,
                             input logic [7:0] nxt, input string nm);
    int loads, shifts, both, line_err, busy_err, done_cyc, p;
    logic exp_line;
    loads = 0; shifts = 0; both = 0; line_err = 0; busy_err = 0; done_cyc = -1;
    total++;
    if (load_enable !== 1'b1) begin
      bad++;
      $display("FAIL %s_load_cycle got=%b want=1", nm, load_enable);
    end
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (load_enable === 1'b1) loads++;
      if (shift_enable === 1'b1) shifts++;
      if (load_enable === 1'b1 && shift_enable === 1'b1) both++;
      if (tx_busy !== 1'b1 && tx_done !== 1'b1) busy_err++;
      if (cyc >= 2) begin
        p = (cyc - 2) / 10;
        if (p == 0)      exp_line = 1'b0;
        else if (p <= 8) exp_line = d[8-p];
        else             exp_line = 1'b1;
        if (tx_line !== exp_line) line_err++;
      end
      if (cyc == 1) begin
        if (hold) tx_data = nxt;
        else      tx_valid = 1'b0;
      end
      if (inject_at != 0 && cyc == inject_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end
      if (inject_at != 0 && cyc == inject_at + 1) tx_valid = 1'b0;
      if (tx_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    total++;
    if (line_err != 0) begin bad++; $display("FAIL %s_line_errs got=%0d want=0", nm, line_err); end
    total++;
    if (busy_err != 0) begin bad++; $display("FAIL %s_busy_errs got=%0d want=0", nm, busy_err); end
    total++;
    if (loads != 1) begin bad++; $display("FAIL %s_loads got=%0d want=1", nm, loads); end
    total++;
    if (shifts != 8) begin bad++; $display("FAIL %s_shifts got=%0d want=8", nm, shifts); end
    total++;
    if (both != 0) begin bad++; $display("FAIL %s_load_and_shift got=%0d want=0", nm, both); end
    total++;
    if (done_cyc != 102) begin bad++; $display("FAIL %s_done_cycle got=%0d want=102", nm, done_cyc); end
    total++;
    if (sr_data !== d) begin bad++; $display("FAIL %s_sr_data got=%h want=%h", nm, sr_data, d); end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready_after got=%b/%b want=1/0", nm, tx_ready, tx_busy);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (tx_line !== 1'b1) begin bad++; $display("FAIL rst_line got=%b want=1", tx_line); end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", tx_ready); end
    total++;
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", tx_busy); end
    total++;
    if ({load_enable, shift_enable, tx_done} !== 3'b000) begin
      bad++;
      $display("FAIL rst_strobes got=%b want=000", {load_enable, shift_enable, tx_done});
    end
    total++;
    if (sr_data !== 8'h00) begin bad++; $display("FAIL rst_sr_data got=%h want=00", sr_data); end
    total++;
    if (f_line !== 1'b1 || f_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_fast got=%b/%b want=1/1", f_line, f_ready);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    start_frame(8'hA5, "single");
    watch_frame(8'hA5, 0, 1'b0, 8'h00, "single");
  endtask

  task automatic test_busy_reject();
    start_frame(8'hFF, "reject");
    watch_frame(8'hFF, 40, 1'b0, 8'h00, "reject");
  endtask

  task automatic test_back_to_back();
    start_frame(8'h00, "b2b0");
    watch_frame(8'h00, 0, 1'b1, 8'hFF, "b2b0");
    @(negedge clk);
    watch_frame(8'hFF, 0, 1'b0, 8'h00, "b2b1");
  endtask

  task automatic test_async_reset();
    start_frame(8'h5A, "areset");
    tx_valid = 1'b0;
    repeat (46) @(negedge clk);
    total++;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL areset_busy_before got=%b want=1", tx_busy); end
    n_rst = 1'b0;
    #1;
    total++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL areset_abort got=%b%b%b want=101", tx_line, tx_busy, tx_ready);
    end
    @(negedge clk);
    n_rst = 1'b1;
    start_frame(8'hC3, "after_rst");
    watch_frame(8'hC3, 0, 1'b0, 8'h00, "after_rst");
  endtask

  task automatic test_fast();
    int shifts, first_sh, last_sh, line_err, done_cyc, waited;
    logic exp_line;
    logic [7:0] d;
    d = 8'h81;
    shifts = 0; first_sh = -1; last_sh = -1; line_err = 0; done_cyc = -1; waited = 0;
    @(negedge clk);
    while (f_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    f_valid = 1'b1;
    f_data  = d;
    @(negedge clk);
    total++;
    if (f_load !== 1'b1) begin bad++; $display("FAIL fast_load got=%b want=1", f_load); end
    f_valid = 1'b0;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (f_shift === 1'b1) begin
        shifts++;
        if (first_sh < 0) first_sh = cyc;
        last_sh = cyc;
      end
      if (cyc == 2)       exp_line = 1'b0;
      else if (cyc <= 10) exp_line = d[10-cyc];
      else                exp_line = 1'b1;
      if (f_line !== exp_line) line_err++;
      if (f_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    total++;
    if (shifts != 8) begin bad++; $display("FAIL fast_shifts got=%0d want=8", shifts); end
    total++;
    if (first_sh != 3 || last_sh != 10) begin
      bad++;
      $display("FAIL fast_shift_window got=%0d..%0d want=3..10", first_sh, last_sh);
    end
    total++;
    if (line_err != 0) begin bad++; $display("FAIL fast_line_errs got=%0d want=0", line_err); end
    total++;
    if (done_cyc != 13) begin bad++; $display("FAIL fast_done_cycle got=%0d want=13", done_cyc); end
    @(negedge clk);
    total++;
    if (f_ready !== 1'b1) begin bad++; $display("FAIL fast_ready_after got=%b want=1", f_ready); end
  endtask

  initial begin
    n_rst    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    f_valid  = 1'b0;
    f_data   = 8'h00;
    test_reset();
    test_single_frame();
    test_busy_reject();
    test_back_to_back();
    test_async_reset();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
